comparator_serial_msb: RTL and testbench
========================================

COMPARATOR_SERIAL_MSB -- requirements
Module: comparator_serial_msb

Interface
REQ-001 SHALL have parameter nb_bits, default 32, meaning operand width; legal range 2 to 64.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  request; accepted on a rising edge where start_i and ready_o are both 1.
REQ-005 SHALL have port signed_i  input  1  1 = two's-complement compare, 0 = unsigned; sampled at acceptance.
REQ-006 SHALL have port A_i  input  nb_bits  operand A; sampled at acceptance.
REQ-007 SHALL have port B_i  input  nb_bits  operand B; sampled at acceptance.
REQ-008 SHALL have port ready_o  output  1  block can accept a request.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse; result flags valid from this cycle on.
REQ-010 SHALL have ports greater_o, equal_o, lesser_o  output  1 each  registered result flags: A>B, A==B, A<B.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, DONE; IDLE->SCAN on acceptance; SCAN->DONE on decision; DONE->SCAN on acceptance, else DONE->IDLE.
REQ-012 SHALL register A_i, B_i, signed_i at the accepting edge E0; operand or signed_i changes afterwards SHALL NOT affect the result.
REQ-013 SHALL examine exactly one bit per SCAN cycle, MSB first: bit nb_bits-1 in the cycle after E0, then descending index.
REQ-014 SHALL, at the MSB and only when signed compare is in effect, invert the decision: A=0,B=1 gives greater; A=1,B=0 gives lesser.
REQ-015 SHALL, at all other bits and in unsigned mode at every bit, give greater for A=1,B=0 and lesser for A=0,B=1.
REQ-016 SHALL decide equal when bit 0 is examined and no bit has differed.
REQ-017 SHALL update the flags and assert done_o for exactly one cycle (the DONE cycle) at the edge following the decisive bit.
REQ-018 SHALL keep exactly one of greater_o/equal_o/lesser_o high after the first completed compare; flags hold until the next done_o.
REQ-019 SHALL drive ready_o=1 in IDLE and DONE and ready_o=0 in SCAN; start_i during SCAN SHALL be ignored, not queued.
REQ-020 SHALL support back-to-back acceptance in the DONE cycle; new SCAN begins with no idle cycle.
REQ-021 SHALL keep the bit-index counter ceil(log2(nb_bits)) bits wide, with no wrap below 0; the bit-0 decision always ends SCAN.

Reset
REQ-022 SHALL, while rst_n_i=0, immediately force state IDLE, ready_o=1, done_o=0, greater_o=0, equal_o=0, lesser_o=0, and clear the index and operand registers.
REQ-023 SHALL abort an in-flight SCAN on reset, with no done_o pulse for the aborted request.
REQ-024 SHALL accept a request at the first rising edge after rst_n_i deasserts.

Configuration
REQ-025 SHALL honour macro COMP_EARLY_EXIT_EN, controlling early exit.
REQ-026 SHALL, when COMP_EARLY_EXIT_EN is defined, decide at the first differing bit d, with done_o rising at edge E0+(nb_bits-d).
REQ-027 SHALL, when COMP_EARLY_EXIT_EN is undefined, latch the first difference but always scan to bit 0, with done_o rising at edge E0+nb_bits for every input; flags SHALL be identical in both builds.

Verification (nb_bits=32)
REQ-028 SHALL cover: early exit defined, A=0x80000000, B=0x7FFFFFFF, signed_i=0 -> greater_o=1, done_o at E0+1; same operands with signed_i=1 -> lesser_o=1, done_o at E0+1.
REQ-029 SHALL cover: A=B=0x12345678 -> equal_o=1, done_o at E0+32; A=5, B=4 -> greater_o=1, done_o at E0+32.
REQ-030 SHALL cover: signed_i=1, A=0xFFFFFFFF (-1), B=0x00000001 -> lesser_o=1; operands changed during SCAN -> result unchanged.
REQ-031 SHALL cover: start_i held during SCAN -> ignored; start_i in DONE cycle with A=1, B=2 -> next SCAN immediate, lesser_o=1 at E0'+31.
REQ-032 SHALL cover: rst_n_i pulsed low mid-SCAN -> all outputs at reset values asynchronously, no done_o pulse; next request completes normally.
REQ-033 SHALL cover: COMP_EARLY_EXIT_EN undefined, A=0x80000000, B=0 -> greater_o=1, done_o at E0+32.

Source files
------------

// File: rtl/comparator_serial_msb.sv
// rtl/comparator_serial_msb.sv - bit-serial MSB-first magnitude comparator, signed or unsigned
// Optional macro COMP_EARLY_EXIT_EN: stop scanning at the first differing bit.
module comparator_serial_msb #(
   parameter int nb_bits = 32
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [nb_bits-1:0] A_i,
   input  logic [nb_bits-1:0] B_i,
   output logic               ready_o,
   output logic               done_o,
   output logic               greater_o,
   output logic               equal_o,
   output logic               lesser_o
);

   localparam int iw = $clog2(nb_bits);
   localparam logic [iw-1:0] top_idx = iw'(nb_bits - 1);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t             state;
   state_t             state_nx;
   logic [nb_bits-1:0] a_q;
   logic [nb_bits-1:0] b_q;
   logic               sgn_q;
   logic [iw-1:0]      idx;

   logic               accept;
   logic               bit_a;
   logic               bit_b;
   logic               differ;
   logic               bit_gt;
   logic               decide;
   logic               res_eq;
   logic               res_gt;

`ifndef COMP_EARLY_EXIT_EN
   logic               diff_q;
   logic               gt_q;
`endif

   assign ready_o = (state != SCAN);
   assign done_o  = (state == DONE);
   assign accept  = start_i && ready_o;

   always_comb begin
      bit_a  = a_q[idx];
      bit_b  = b_q[idx];
      differ = bit_a ^ bit_b;
      // The sign bit carries negative weight, so a set MSB on B means A is larger.
      bit_gt = (sgn_q && (idx == top_idx)) ? bit_b : bit_a;
`ifdef COMP_EARLY_EXIT_EN
      decide = differ || (idx == '0);
      res_eq = !differ;
      res_gt = differ && bit_gt;
`else
      decide = (idx == '0);
      res_eq = !diff_q && !differ;
      res_gt = diff_q ? gt_q : (differ && bit_gt);
`endif
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = SCAN;
         SCAN:    if (decide) state_nx = DONE;
         DONE:    state_nx = accept ? SCAN : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nx;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         a_q   <= '0;
         b_q   <= '0;
         sgn_q <= 1'b0;
         idx   <= '0;
`ifndef COMP_EARLY_EXIT_EN
         diff_q <= 1'b0;
         gt_q   <= 1'b0;
`endif
      end else if (accept) begin
         a_q   <= A_i;
         b_q   <= B_i;
         sgn_q <= signed_i;
         idx   <= top_idx;
`ifndef COMP_EARLY_EXIT_EN
         diff_q <= 1'b0;
         gt_q   <= 1'b0;
`endif
      end else if (state == SCAN) begin
         if (idx != '0) idx <= idx - 1'b1;
`ifndef COMP_EARLY_EXIT_EN
         // Only the first (most significant) difference decides the result.
         if (differ && !diff_q) begin
            diff_q <= 1'b1;
            gt_q   <= bit_gt;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         greater_o <= 1'b0;
         equal_o   <= 1'b0;
         lesser_o  <= 1'b0;
      end else if ((state == SCAN) && decide) begin
         greater_o <= !res_eq && res_gt;
         equal_o   <= res_eq;
         lesser_o  <= !res_eq && !res_gt;
      end
   end

endmodule

// File: tb/tb_comparator_serial_msb.sv
// tb/tb_comparator_serial_msb.sv - self-checking bench for comparator_serial_msb (nb_bits=32)
// Latency expectations follow COMP_EARLY_EXIT_EN when it is defined for the build.
module tb_comparator_serial_msb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        sgn = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        ready, done, gt, eq, lt;

   comparator_serial_msb #(.nb_bits(32)) dut (
      .clk_i     (clk),
      .rst_n_i   (rst_n),
      .start_i   (start),
      .signed_i  (sgn),
      .A_i       (a),
      .B_i       (b),
      .ready_o   (ready),
      .done_o    (done),
      .greater_o (gt),
      .equal_o   (eq),
      .lesser_o  (lt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [2:0] flags;
      int         lat;
      int         e0;
   } exp_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      logic [2:0]  flags;
   } vec_t;

   localparam logic [2:0] GT = 3'b100;
   localparam logic [2:0] EQ = 3'b010;
   localparam logic [2:0] LT = 3'b001;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic prev_done = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic int exp_lat(input logic [31:0] x, input logic [31:0] y);
      int d;
      d = -1;
      for (int i = 31; i >= 0; i--) begin
         if (d < 0 && x[i] != y[i]) d = i;
      end
`ifdef COMP_EARLY_EXIT_EN
      return (d < 0) ? 32 : 32 - d;
`else
      return 32;
`endif
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         check("done_pulse_width", {31'b0, prev_done}, 32'd0);
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_done: got done with no pending request at cycle %0d", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("flags", {29'b0, gt, eq, lt}, {29'b0, e.flags});
            check("latency", cyc - e.e0, e.lat);
         end
      end
      prev_done = rst_n && done;
   end

   task automatic accept_now(input logic [31:0] x, input logic [31:0] y, input logic s,
                             input logic [2:0] f);
      exp_t e;
      a = x;
      b = y;
      sgn = s;
      start = 1'b1;
      @(posedge clk);
      #1;
      e.flags = f;
      e.lat   = exp_lat(x, y);
      e.e0    = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_ready();
      int t;
      t = 0;
      @(negedge clk);
      while (!ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL ready_timeout: ready stayed low at cycle %0d", cyc);
      end
   endtask

   task automatic wait_empty();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: %0d requests pending at cycle %0d", sb.size(), cyc);
         sb.delete();
      end
   endtask

   task automatic req(input logic [31:0] x, input logic [31:0] y, input logic s,
                      input logic [2:0] f, input int hold, input bit wiggle);
      wait_ready();
      accept_now(x, y, s, f);
      @(negedge clk);
      for (int i = 0; i < hold; i++) @(negedge clk);
      start = 1'b0;
      if (wiggle) begin
         for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            sgn = ~sgn;
            @(negedge clk);
         end
      end
      wait_empty();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {31'b0, ready}, 32'd1);
      check({tag, "_done"},  {31'b0, done},  32'd0);
      check({tag, "_flags"}, {29'b0, gt, eq, lt}, 32'd0);
   endtask

   vec_t vecs[12];

   initial begin
      vecs[0]  = '{32'h80000000, 32'h7FFFFFFF, 1'b0, GT};
      vecs[1]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, LT};
      vecs[2]  = '{32'h12345678, 32'h12345678, 1'b0, EQ};
      vecs[3]  = '{32'h00000005, 32'h00000004, 1'b0, GT};
      vecs[4]  = '{32'hFFFFFFFF, 32'h00000001, 1'b1, LT};
      vecs[5]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, GT};
      vecs[6]  = '{32'h00000001, 32'h00000002, 1'b0, LT};
      vecs[7]  = '{32'h80000000, 32'h00000000, 1'b0, GT};
      vecs[8]  = '{32'h00000000, 32'h00000000, 1'b1, EQ};
      vecs[9]  = '{32'h7FFFFFFF, 32'h80000000, 1'b1, GT};
      vecs[10] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, LT};
      vecs[11] = '{32'h00010000, 32'h00008000, 1'b0, GT};

      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++)
         req(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].flags, 0, 1'b0);

      repeat (3) @(negedge clk);
      check("flags_hold", {29'b0, gt, eq, lt}, {29'b0, GT});

      // Operands and signedness scrambled after acceptance must not matter.
      req(32'hFFFFFFFF, 32'h00000001, 1'b1, LT, 0, 1'b1);
      req(32'h00000005, 32'h00000004, 1'b0, GT, 0, 1'b1);

      // start held through SCAN must not queue a second request.
      req(32'h00000005, 32'h00000004, 1'b0, GT, 10, 1'b0);
      repeat (40) @(negedge clk);

      // Back-to-back: new request accepted in the DONE cycle.
      wait_ready();
      accept_now(32'h00000005, 32'h00000004, 1'b0, GT);
      @(negedge clk);
      start = 1'b0;
      begin
         int t;
         t = 0;
         while (!done && t < 100) begin
            @(negedge clk);
            t++;
         end
      end
      check("b2b_done_seen", {31'b0, done}, 32'd1);
      check("b2b_ready_in_done", {31'b0, ready}, 32'd1);
      accept_now(32'h00000001, 32'h00000002, 1'b0, LT);
      check("b2b_scan_immediate", {31'b0, ready}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      wait_empty();

      // Reset pulsed mid-SCAN: asynchronous clear, aborted request never completes.
      wait_ready();
      accept_now(32'h00000005, 32'h00000004, 1'b0, GT);
      @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      check("pre_reset_busy", {31'b0, ready}, 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midscan_reset");
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      accept_now(32'h80000000, 32'h00000000, 1'b0, GT);
      @(negedge clk);
      start = 1'b0;
      wait_empty();
      repeat (5) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
